// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

    // Arbiter ownership state
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_DMA_LOCK = 1'b1
    } state_t;

    // Requester identifiers, used for response steering and round-robin history
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    // Default geometry of the data memory (32 words x 32 bits)
    localparam int DEF_AW = 5;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/dm_arb_rsp.sv
// One-cycle read response tracker: remembers which port issued a read and
// steers the memory's registered read data back to that port.
module dm_arb_rsp
    import dm_arb_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_issue,
    input  logic          rd_port,
    input  logic [DW-1:0] dm_rd,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata
);

    logic rvalid_q;
    logic port_q;

    // Capture the read issued this cycle; reset drops any response in flight
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            port_q   <= PORT_CORE;
        end else begin
            rvalid_q <= rd_issue;
            port_q   <= rd_port;
        end
    end

    // Route the memory read data to the owning port; idle rdata is held at zero
    always_comb begin
        c_rvalid = rvalid_q && (port_q == PORT_CORE);
        d_rvalid = rvalid_q && (port_q == PORT_DMA);
        c_rdata  = c_rvalid ? dm_rd : '0;
        d_rdata  = d_rvalid ? dm_rd : '0;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the core
// LSU (c_*) and a DMA/debug engine (d_*). The DMA may lock the memory for
// bursts, bounded to MAX_BURST beats once the core is waiting.
// Optional build macro DM_ARB_RR_EN: round-robin arbitration in IDLE instead
// of fixed core-first priority.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_last,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wd,
    output logic          dm_we,
    input  logic [DW-1:0] dm_rd
);

    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    state_t        state_q, state_d;
    logic [CW-1:0] beat_q, beat_d, beat_inc;
    logic          rd_issue;
    logic          rd_port;
`ifdef DM_ARB_RR_EN
    logic          last_q, last_d;
`endif

    // Grant selection; all grants are held low while reset is asserted
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (state_q == ST_DMA_LOCK) begin
                d_gnt = d_req;
                c_gnt = c_req && !d_req;
            end else if (c_req && d_req) begin
`ifdef DM_ARB_RR_EN
                c_gnt = (last_q == PORT_DMA);
                d_gnt = (last_q == PORT_CORE);
`else
                c_gnt = 1'b1;
`endif
            end else begin
                c_gnt = c_req;
                d_gnt = d_req;
            end
        end
    end

    // Beat count including the beat being accepted now, saturating at MAX_BURST
    always_comb begin
        beat_inc = (beat_q == BURST_MAX) ? beat_q : beat_q + 1'b1;
    end

    // Lock entry/exit; a burst is cut after its MAX_BURST-th beat if the core waits
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
`ifdef DM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef DM_ARB_RR_EN
                if (c_req && d_req) begin
                    last_d = d_gnt ? PORT_DMA : PORT_CORE;
                end
`endif
                if (d_gnt && !d_last) begin
                    state_d = ST_DMA_LOCK;
                    beat_d  = CW'(1);
                end
            end
            ST_DMA_LOCK: begin
                if (!d_req) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else if (d_last) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else if (c_req && (beat_inc == BURST_MAX)) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
`ifdef DM_ARB_RR_EN
                    // Forced release always hands the next cycle to the core
                    last_d  = PORT_DMA;
`endif
                end else begin
                    beat_d = beat_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
`ifdef DM_ARB_RR_EN
            last_q  <= PORT_CORE;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
`ifdef DM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Drive the memory from the granted port; quiet (all zero) with no grant
    always_comb begin
        dm_addr = '0;
        dm_wd   = '0;
        dm_we   = 1'b0;
        if (c_gnt) begin
            dm_addr = c_addr;
            dm_wd   = c_wdata;
            dm_we   = c_we;
        end else if (d_gnt) begin
            dm_addr = d_addr;
            dm_wd   = d_wdata;
            dm_we   = d_we;
        end
    end

    assign rd_issue = (c_gnt && !c_we) || (d_gnt && !d_we);
    assign rd_port  = d_gnt ? PORT_DMA : PORT_CORE;

    dm_arb_rsp #(
        .DW (DW)
    ) u_rsp (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_issue (rd_issue),
        .rd_port  (rd_port),
        .dm_rd    (dm_rd),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata)
    );

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by random
// traffic, checked against a burst-level reference model and a read-data
// scoreboard.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    localparam int AW        = 5;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
    localparam int NW        = 1 << AW;
`ifdef DM_ARB_RR_EN
    localparam bit FIRST_CORE = 1'b0;
`else
    localparam bit FIRST_CORE = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          d_req = 1'b0, d_we = 1'b0, d_last = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid, dm_we;
    logic [DW-1:0] c_rdata, d_rdata, dm_wd;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_rd = '0;
    logic [DW-1:0] mem [NW];

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [NW];
    logic [DW-1:0] cq[$];
    logic [DW-1:0] dq[$];
    bit            m_lock;
    int            m_beats;
`ifdef DM_ARB_RR_EN
    bit            m_last_dma;
`endif
    bit            eg_c, eg_d;
    logic          obs_c, obs_d, obs_drv, obs_crv, obs_we;
    logic [DW-1:0] obs_crd;

    dm_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_last(d_last), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    // Single-port data memory with registered read
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_wd;
        dm_rd <= mem[dm_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected grants from the arbitration rules
    function automatic void model_grants();
        eg_c = 1'b0;
        eg_d = 1'b0;
        if (!rst_n) return;
        if (m_lock) begin
            if (d_req) eg_d = 1'b1;
            else       eg_c = c_req;
        end else if (c_req && d_req) begin
`ifdef DM_ARB_RR_EN
            if (m_last_dma) eg_c = 1'b1;
            else            eg_d = 1'b1;
`else
            eg_c = 1'b1;
`endif
        end else begin
            eg_c = c_req;
            eg_d = d_req;
        end
    endfunction

    function automatic void model_reset();
        m_lock  = 1'b0;
        m_beats = 0;
`ifdef DM_ARB_RR_EN
        m_last_dma = 1'b0;
`endif
    endfunction

    // Apply accepted accesses to the reference memory and burst bookkeeping
    function automatic void model_update();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (eg_c) begin
            if (c_we) ref_mem[c_addr] = c_wdata;
            else      cq.push_back(ref_mem[c_addr]);
        end
        if (eg_d) begin
            if (d_we) ref_mem[d_addr] = d_wdata;
            else      dq.push_back(ref_mem[d_addr]);
        end
        if (!m_lock) begin
`ifdef DM_ARB_RR_EN
            if (c_req && d_req) m_last_dma = eg_d;
`endif
            if (eg_d && !d_last) begin
                m_lock  = 1'b1;
                m_beats = 1;
            end
        end else if (!d_req) begin
            m_lock = 1'b0;
        end else begin
            m_beats++;
            if (d_last) begin
                m_lock = 1'b0;
            end else if (c_req && m_beats >= MAX_BURST) begin
                m_lock = 1'b0;
`ifdef DM_ARB_RR_EN
                m_last_dma = 1'b1;
`endif
            end
        end
    endfunction

    // One clock: check grants and memory drive mid-cycle, then advance the model
    task automatic cycle();
        @(negedge clk);
        model_grants();
        obs_c   = c_gnt;
        obs_d   = d_gnt;
        obs_drv = d_rvalid;
        obs_crv = c_rvalid;
        obs_crd = c_rdata;
        obs_we  = dm_we;
        check("c_gnt", c_gnt, eg_c);
        check("d_gnt", d_gnt, eg_d);
        check("dm_we", dm_we, eg_c ? c_we : (eg_d ? d_we : 1'b0));
        check("dm_addr", dm_addr, eg_c ? c_addr : (eg_d ? d_addr : '0));
        check("dm_wd", dm_wd, eg_c ? c_wdata : (eg_d ? d_wdata : '0));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic core_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n = 0;
        c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wd;
        do begin
            cycle();
            n++;
        end while (!eg_c && n < 20);
        c_req = 1'b0; c_we = 1'b0;
        if (!eg_c) check("core_op timeout", 0, 1);
    endtask

    // Read-data monitor: every rvalid pops the port's expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (c_rvalid) begin
                if (cq.size() == 0) check("c_rvalid spurious", 1, 0);
                else                check("c_rdata", c_rdata, cq.pop_front());
            end else begin
                if (cq.size() != 0) begin
                    check("c_rvalid missing", 0, 1);
                    void'(cq.pop_front());
                end
                check("c_rdata idle", c_rdata, 0);
            end
            if (d_rvalid) begin
                if (dq.size() == 0) check("d_rvalid spurious", 1, 0);
                else                check("d_rdata", d_rdata, dq.pop_front());
            end else begin
                if (dq.size() != 0) begin
                    check("d_rvalid missing", 0, 1);
                    void'(dq.pop_front());
                end
                check("d_rdata idle", d_rdata, 0);
            end
        end
    end

    initial begin
        int beats;
        int core_cyc;
        for (int i = 0; i < NW; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[3]     = 32'hDEADBEEF;
        ref_mem[3] = 32'hDEADBEEF;
        model_reset();

        // Reset: requests present but nothing granted, memory quiet
        c_req = 1'b1; c_addr = 5'd3; c_wdata = 32'h1111_2222;
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd9; d_wdata = 32'h3333_4444; d_last = 1'b1;
        cycle();
        check("rst c_gnt", obs_c, 0);
        check("rst d_gnt", obs_d, 0);
        check("rst dm_we", obs_we, 0);
        check("rst c_rvalid", obs_crv, 0);
        c_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();

        // Core read of preloaded word
        core_op(1'b0, 5'd3, '0);
        cycle();
        check("t1 c_rvalid", obs_crv, 1);
        check("t1 c_rdata", obs_crd, 32'hDEADBEEF);
        check("t1 d_rvalid", obs_drv, 0);

        // Contested request in IDLE
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'd5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 5'd6; d_last = 1'b1;
        cycle();
        check("contest first core", obs_c, FIRST_CORE);
        check("contest first dma", obs_d, !FIRST_CORE);
        if (eg_c) c_req = 1'b0;
        if (eg_d) d_req = 1'b0;
        cycle();
        check("contest second core", obs_c, !FIRST_CORE);
        check("contest second dma", obs_d, FIRST_CORE);
        c_req = 1'b0; d_req = 1'b0;
        cycle();

        // 8-beat DMA write burst with the core waiting from beat 2
        beats = 0; core_cyc = -1;
        d_req = 1'b1; d_we = 1'b1; d_addr = '0; d_wdata = $urandom; d_last = 1'b0;
        for (int n = 1; n <= 40 && beats < 8; n++) begin
            if (beats == 1 && core_cyc < 0 && !c_req) begin
                c_req = 1'b1; c_we = 1'b0; c_addr = 5'd20;
            end
            cycle();
            if (eg_c) begin
                core_cyc = n;
                c_req = 1'b0;
            end
            if (eg_d) begin
                beats++;
                d_addr = AW'(beats); d_wdata = $urandom; d_last = (beats == 7);
                if (beats == 8) d_req = 1'b0;
            end
        end
        check("burst beats", beats, 8);
        check("burst core slot", core_cyc, 5);
        d_req = 1'b0; c_req = 1'b0;
        cycle();
        for (int i = 0; i < 8; i++) check("burst mem word", mem[i], ref_mem[i]);
        for (int i = 0; i < 8; i++) core_op(1'b0, AW'(i), '0);
        cycle();

        // Abandoned burst hands the memory to the core in the same cycle
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd10; d_wdata = 32'hCAFE_0010; d_last = 1'b0;
        cycle();
        d_addr = 5'd11; d_wdata = 32'hCAFE_0011;
        cycle();
        d_req = 1'b0; d_we = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'd10;
        cycle();
        check("abandon core same cycle", obs_c, 1);
        c_req = 1'b0;
        cycle();

        // Top address and wrap to address 0
        core_op(1'b1, 5'd31, 32'h12345678);
        core_op(1'b0, 5'd31, '0);
        cycle();
        check("addr31 rdata", obs_crd, 32'h12345678);
        core_op(1'b1, 5'd0, 32'hA5A5_0F0F);
        core_op(1'b0, 5'd31, '0);
        core_op(1'b0, 5'd0, '0);
        cycle();
        check("addr0 rdata", obs_crd, 32'hA5A5_0F0F);

        // Reset the cycle after a DMA read grant, mid-burst
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd4; d_wdata = 32'h0BAD_F00D; d_last = 1'b0;
        cycle();
        d_we = 1'b0; d_addr = 5'd5;
        cycle();
        rst_n = 1'b0;
        cq.delete();
        dq.delete();
        model_reset();
        d_we = 1'b1; d_addr = 5'd6;
        cycle();
        check("midrst d_rvalid", obs_drv, 0);
        check("midrst dm_we", obs_we, 0);
        check("midrst d_gnt", obs_d, 0);
        c_req = 1'b1; c_we = 1'b0; c_addr = 5'd7;
        d_we = 1'b0; d_last = 1'b1;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("post-rst core first", obs_c, FIRST_CORE);
        for (int n = 0; n < 5 && (c_req || d_req); n++) begin
            if (eg_c) c_req = 1'b0;
            if (eg_d) d_req = 1'b0;
            if (c_req || d_req) cycle();
        end
        c_req = 1'b0; d_req = 1'b0;
        cycle();

        // Random traffic; requesters hold a request until the model accepts it
        eg_c = 1'b0; eg_d = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!c_req || eg_c) begin
                c_req   = ($urandom_range(99) < 50);
                c_we    = 1'($urandom);
                c_addr  = AW'($urandom);
                c_wdata = $urandom;
            end
            if (!d_req || eg_d) begin
                d_req   = ($urandom_range(99) < 60);
                d_we    = 1'($urandom);
                d_addr  = AW'($urandom);
                d_wdata = $urandom;
                d_last  = ($urandom_range(3) == 0);
            end
            cycle();
        end
        c_req = 1'b0; d_req = 1'b0;
        cycle();
        cycle();
        check("core responses drained", cq.size(), 0);
        check("dma responses drained", dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
